// File: rtl/vredsum_seq_if.sv
// vredsum_seq_if: command and register-file port bundle for the vredsum.vs
// sequencer. master = issue stage / register file side, slave = sequencer.
interface vredsum_seq_if #(
  parameter int VLEN_BITS = 128,
  parameter int REG_AW    = 5
);
  // command channel
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_sew;
  logic                 cmd_lmul;
  logic [REG_AW-1:0]    cmd_vs2;
  logic [REG_AW-1:0]    cmd_vs1;
  logic [REG_AW-1:0]    cmd_vd;
  // register-file read port
  logic                 rf_rd_en;
  logic [REG_AW-1:0]    rf_rd_addr;
  logic [VLEN_BITS-1:0] rf_rd_data;
  // register-file write port
  logic                 rf_wr_en;
  logic [REG_AW-1:0]    rf_wr_addr;
  logic [VLEN_BITS-1:0] rf_wr_data;
  logic                 rf_wr_ready;
  // status
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_sew, cmd_lmul, cmd_vs2, cmd_vs1, cmd_vd,
    output rf_rd_data, rf_wr_ready,
    input  cmd_ready, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_sew, cmd_lmul, cmd_vs2, cmd_vs1, cmd_vd,
    input  rf_rd_data, rf_wr_ready,
    output cmd_ready, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output busy, done
  );
endinterface

// File: rtl/vredsum_seq.sv
// vredsum_seq: multi-cycle vredsum.vs sequencer. Reads vs1 then the vs2
// group (1 or 4 registers) one register per cycle, accumulates the
// sign-extended elements in a 40-bit accumulator and writes the scalar
// result into element 0 of vd.
// Optional feature: define VREDSUM_SEQ_SAT_EN to saturate the written result
// to the signed SEW range instead of wrapping.

// Per-32-bit-lane reducer: sum of sign-extended elements in one word.
module vredsum_lane (
  input  logic               sew,
  input  logic [31:0]        word,
  output logic signed [33:0] sum
);
  // int32: the word itself; int8: four bytes summed
  always_comb begin
    if (sew) sum = 34'(signed'(word));
    else     sum = 34'(signed'(word[7:0]))   + 34'(signed'(word[15:8])) +
                   34'(signed'(word[23:16])) + 34'(signed'(word[31:24]));
  end
endmodule

module vredsum_seq #(
  parameter int VLEN_BITS = 128,
  parameter int REG_AW    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  vredsum_seq_if.slave bus
);
  localparam int NUM_LANES = VLEN_BITS / 32;
  localparam int VEC_W     = 32;
  localparam int ACC_W     = 40;
  localparam int STAGES    = 1;

  localparam logic signed [ACC_W-1:0] MAX8  = 40'sd127;
  localparam logic signed [ACC_W-1:0] MIN8  = -40'sd128;
  localparam logic signed [ACC_W-1:0] MAX32 = 40'sd2147483647;
  localparam logic signed [ACC_W-1:0] MIN32 = -40'sd2147483648;

  typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_t;

  state_t                          state;
  logic                            sew_q, lmul_q;
  logic [REG_AW-1:0]               vs2_q;
  logic [2:0]                      cnt;
  logic signed [ACC_W-1:0]         acc;
  // [0]: read issued this cycle, [1]: its data is on rf_rd_data this cycle
  logic [STAGES:0]                 vld_pipe;
  // tags the vs1 read as it travels through vld_pipe
  logic [STAGES:0]                 vs1_pipe;

  logic                            cmd_ready_q, busy_q, done_q, wr_en_q;
  logic [REG_AW-1:0]               rd_addr_q, wr_addr_q;
  logic [VLEN_BITS-1:0]            wr_data_q;

  logic [NUM_LANES-1:0][VEC_W-1:0] rd_words;
  logic [NUM_LANES-1:0][33:0]      lane_sum;
  logic signed [ACC_W-1:0]         reg_sum, vs1_elem, acc_nxt;
  logic [VLEN_BITS-1:0]            result;
  logic [2:0]                      last_cnt;

  assign rd_words = bus.rf_rd_data;
  assign last_cnt = lmul_q ? 3'd4 : 3'd1;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vredsum_lane u_lane (
      .sew  (sew_q),
      .word (rd_words[l]),
      .sum  (lane_sum[l])
    );
  end

  // whole-register sum across lanes
  always_comb begin
    reg_sum = '0;
    for (int l = 0; l < NUM_LANES; l++)
      reg_sum = reg_sum + ACC_W'(signed'(lane_sum[l]));
  end

  // element 0 of vs1, sign-extended per SEW
  always_comb begin
    vs1_elem = sew_q ? ACC_W'(signed'(rd_words[0])) : ACC_W'(signed'(rd_words[0][7:0]));
  end

  // next accumulator: vs1 seeds it, each vs2 register adds its sum
  always_comb begin
    acc_nxt = acc;
    if (vld_pipe[1]) acc_nxt = vs1_pipe[1] ? vs1_elem : acc + reg_sum;
  end

  // write-back formatting from the final accumulator; upper bits stay zero
  always_comb begin
    result = '0;
`ifdef VREDSUM_SEQ_SAT_EN
    if (sew_q)
      result[31:0] = (acc_nxt > MAX32) ? 32'h7FFF_FFFF :
                     (acc_nxt < MIN32) ? 32'h8000_0000 : acc_nxt[31:0];
    else
      result[7:0]  = (acc_nxt > MAX8) ? 8'h7F :
                     (acc_nxt < MIN8) ? 8'h80 : acc_nxt[7:0];
`else
    if (sew_q) result[31:0] = acc_nxt[31:0];
    else       result[7:0]  = acc_nxt[7:0];
`endif
  end

  // sequencer FSM with registered outputs and read-valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sew_q       <= 1'b0;
      lmul_q      <= 1'b0;
      vs2_q       <= '0;
      cnt         <= '0;
      acc         <= '0;
      vld_pipe    <= '0;
      vs1_pipe    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      vld_pipe[1] <= vld_pipe[0];
      vs1_pipe[1] <= vs1_pipe[0];
      acc         <= acc_nxt;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sew_q       <= bus.cmd_sew;
            lmul_q      <= bus.cmd_lmul;
            vs2_q       <= bus.cmd_vs2;
            wr_addr_q   <= bus.cmd_vd;
            rd_addr_q   <= bus.cmd_vs1;
            cnt         <= '0;
            acc         <= '0;
            vld_pipe[0] <= 1'b1;
            vs1_pipe[0] <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= RD;
          end
        end
        RD: begin
          vs1_pipe[0] <= 1'b0;
          cnt         <= cnt + 3'd1;
          if (cnt == last_cnt) begin
            // last read issued this cycle; address holds its value
            vld_pipe[0] <= 1'b0;
            state       <= DRAIN;
          end else begin
            rd_addr_q <= vs2_q + REG_AW'(cnt);
          end
        end
        DRAIN: begin
          wr_data_q <= result;
          wr_en_q   <= 1'b1;
          state     <= WR;
        end
        WR: begin
          if (bus.rf_wr_ready) begin
            wr_en_q     <= 1'b0;
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rf_rd_en   = vld_pipe[0];
  assign bus.rf_rd_addr = rd_addr_q;
  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;
endmodule
